// File: rtl/dmem_pkg.sv
// ============================================================================
// Package : dmem_pkg
// Shared size codes, FSM state type and constants for dmem_access_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_store_align.sv
// ============================================================================
// Module  : dmem_store_align
// Byte-enable, store-lane replication and alignment check for one access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        be        = BE_ALL;
        misalign  = |addr_lo;
      end
      default: begin
        // Reserved size code is reported as a fault, never reaches the bus
        misalign  = 1'b1;
      end
    endcase
  end

endmodule : dmem_store_align

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module  : dmem_access_ctrl
// CPU-to-data-memory access FSM with bus timeout and load capture registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_misalign,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_bite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bite;

  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_misalign;
  logic [CNT_W-1:0] w_cnt_nxt;

  dmem_store_align u_align (
    .size      (cpu_size),
    .addr_lo   (cpu_addr[1:0]),
    .wdata     (cpu_wdata),
    .be        (w_be),
    .wdata_rep (w_wdata),
    .misalign  (w_misalign)
  );

  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // Low in DONE so the CPU advances exactly once per access
  assign cpu_stall = ((r_state == IDLE) && cpu_req && !w_misalign) || (r_state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bite       <= 2'b00;
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_misalign <= 1'b0;
      cpu_rdata    <= 32'h0;
      cpu_bite     <= 2'b00;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
    end else begin
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            if (w_misalign) begin
              cpu_done     <= 1'b1;
              cpu_misalign <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_be    <= cpu_we ? w_be : BE_ALL;
              mem_wdata <= w_wdata;
              r_bite    <= cpu_addr[1:0];
              r_cnt     <= '0;
              r_state   <= REQ;
            end
          end
        end
        REQ: begin
          // An ack arriving on the timeout cycle still completes normally
          if (mem_ack) begin
            mem_req  <= 1'b0;
            cpu_done <= 1'b1;
            if (!mem_we) begin
              cpu_rdata <= mem_rdata;
              cpu_bite  <= r_bite;
            end
            r_state  <= DONE;
          end else if (w_cnt_nxt == C_TIMEOUT) begin
            mem_req  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_state  <= DONE;
          end else begin
            r_cnt    <= w_cnt_nxt;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : dmem_access_ctrl

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module  : tb_dmem_access_ctrl
// Self-checking bench for dmem_access_ctrl with a byte-lane reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

  localparam int TIMEOUT_CYCLES = 4;
  localparam int CNT_W          = 8;
  localparam int NO_ACK         = 99;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_misalign;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_bite;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests;
  int n_fail;

  // Architectural view of the load-result registers
  logic [31:0] m_rdata;
  logic [1:0]  m_bite;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_misalign (cpu_misalign),
    .cpu_rdata    (cpu_rdata),
    .cpu_bite     (cpu_bite),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Access modelled as a run of byte lanes starting at addr%4
  function automatic void model_access(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] wd, output logic [3:0] be,
                                       output logic [31:0] wrep, output bit mis);
    int nbytes;
    int off;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    off    = int'(addr[1:0]);
    mis    = (nbytes == 0) || ((off % nbytes) != 0);
    be     = 4'b0000;
    wrep   = 32'h0;
    if (!mis) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nbytes) be[i] = 1'b1;
        wrep[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      end
    end
  endfunction

  // Full CPU-side transaction; ack_delay = REQ cycles before ack (>= TIMEOUT means no ack)
  task automatic do_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input int ack_delay, input logic [31:0] rd);
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    bit          mis;
    bit          acked;
    int          k;
    model_access(size, addr, wd, e_be, e_wd, mis);
    if (!we) e_be = 4'b1111;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wd;
    #1;
    n_tests++;
    if (cpu_stall !== !mis) begin
      n_fail++; $display("FAIL req_stall addr=%h: got %b want %b", addr, cpu_stall, !mis);
    end
    @(posedge clk); #1;
    if (mis) begin
      cpu_req = 1'b0;
      n_tests++;
      if ({cpu_done, cpu_misalign, cpu_err, mem_req} !== 4'b1100) begin
        n_fail++; $display("FAIL misalign_pulse addr=%h size=%0d: done/mis/err/req got %b want 1100",
                           addr, size, {cpu_done, cpu_misalign, cpu_err, mem_req});
      end
      @(posedge clk); #1;
      n_tests++;
      if ({cpu_done, cpu_misalign, mem_req} !== 3'b000) begin
        n_fail++; $display("FAIL misalign_clear: done/mis/req got %b want 000",
                           {cpu_done, cpu_misalign, mem_req});
      end
      return;
    end
    n_tests++;
    if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== e_be || mem_we !== we) begin
      n_fail++; $display("FAIL bus_fields addr=%h: addr/be/we got %h/%b/%b want %h/%b/%b",
                         addr, mem_addr, mem_be, mem_we, {addr[31:2], 2'b00}, e_be, we);
    end
    if (we) begin
      n_tests++;
      if (mem_wdata !== e_wd) begin
        n_fail++; $display("FAIL bus_wdata addr=%h: got %h want %h", addr, mem_wdata, e_wd);
      end
    end
    acked = 1'b0;
    k = 0;
    while (1) begin
      n_tests++;
      if (mem_req !== 1'b1 || cpu_stall !== 1'b1 || cpu_done !== 1'b0) begin
        n_fail++; $display("FAIL req_hold cyc=%0d: req/stall/done got %b%b%b want 110",
                           k, mem_req, cpu_stall, cpu_done);
      end
      if (k == ack_delay) begin
        mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (acked || k + 1 >= TIMEOUT_CYCLES) break;
      k++;
    end
    if (acked && !we) begin
      m_rdata = rd; m_bite = addr[1:0];
    end
    n_tests++;
    if ({cpu_done, cpu_err, cpu_misalign, mem_req, cpu_stall} !== {1'b1, !acked, 3'b000}) begin
      n_fail++; $display("FAIL done_pulse addr=%h: done/err/mis/req/stall got %b want %b", addr,
                         {cpu_done, cpu_err, cpu_misalign, mem_req, cpu_stall}, {1'b1, !acked, 3'b000});
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n_tests++;
    if (cpu_done !== 1'b0 || cpu_err !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL after_done: done/err/req got %b%b%b want 000", cpu_done, cpu_err, mem_req);
    end
    n_tests++;
    if (cpu_rdata !== m_rdata || cpu_bite !== m_bite) begin
      n_fail++; $display("FAIL load_result addr=%h: rdata/bite got %h/%0d want %h/%0d",
                         addr, cpu_rdata, cpu_bite, m_rdata, m_bite);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    m_rdata = 32'h0; m_bite = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({mem_req, mem_we, cpu_done, cpu_err, cpu_misalign, cpu_stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                         {mem_req, mem_we, cpu_done, cpu_err, cpu_misalign, cpu_stall});
    end
    n_tests++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 ||
        cpu_rdata !== 32'h0 || cpu_bite !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: addr/be/wd/rd/bite got %h/%h/%h/%h/%0d want zeros",
                         mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_bite);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_access(1'b0, 2'b10, 32'h0000_0100, 32'h0, 0, 32'hDEADBEEF);
    do_access(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0);
    do_access(1'b1, 2'b01, 32'h0000_0302, 32'h0000_1234, 2, 32'h0);
    do_access(1'b0, 2'b01, 32'h0000_0301, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'b11, 32'h0000_0400, 32'h55, 0, 32'h0);
  endtask

  task automatic test_timeout();
    do_access(1'b0, 2'b10, 32'h0000_0040, 32'h0, NO_ACK, 32'h0BAD_0BAD);
    do_access(1'b0, 2'b00, 32'h0000_0043, 32'h0, TIMEOUT_CYCLES - 1, 32'hCAFE_F00D);
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || cpu_done !== 1'b0 || cpu_rdata !== m_rdata) begin
      n_fail++; $display("FAIL stray_ack: req/done/rdata got %b/%b/%h want 0/0/%h",
                         mem_req, cpu_done, cpu_rdata, m_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 2'b01, 32'h0000_1002, 32'h0, 0, 32'h1111_2222);
    do_access(1'b1, 2'b10, 32'h0000_1004, 32'h3333_4444, 0, 32'h0);
    do_access(1'b0, 2'b00, 32'h0000_1001, 32'h0, 0, 32'h5555_6666);
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_0080;
    @(posedge clk); #1;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL midrst_setup: mem_req got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: mem_req got %b want 0", mem_req);
    end
    cpu_req = 1'b0;
    m_rdata = 32'h0; m_bite = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_req !== 1'b0 || cpu_done !== 1'b0 || cpu_err !== 1'b0 ||
        cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL midrst_late_ack: req/done/err/stall/rdata got %b%b%b%b/%h want 0000/0",
                         mem_req, cpu_done, cpu_err, cpu_stall, cpu_rdata);
    end
    do_access(1'b0, 2'b10, 32'h0000_0084, 32'h0, 1, 32'h8765_4321);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_access(1'($urandom), 2'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TIMEOUT_CYCLES + 1)), $urandom);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_timeout();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_access_ctrl

`default_nettype wire
